// File: rtl/rr_arb_mux.sv
// -----------------------------------------------------------------------------
// rr_arb_mux
//
// Purpose:
//   N-channel arbitrating multiplexer feeding a single output register stage.
//   Each cycle one requesting channel is granted, either by fixed priority
//   (lowest index wins) or by round robin starting after the most recently
//   served channel. The granted item is captured into the output register,
//   which behaves as a one-entry valid/ready pipeline stage with full
//   throughput (a held item can be consumed and replaced in the same cycle).
//
// Parameters:
//   WIDTH  data width per channel
//   N      number of input channels (2..16)
//   SEL_W  channel index width, always $clog2(N) (not overridable)
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous, active-high reset
//   mode       0 = fixed priority, 1 = round robin
//   in_valid   per-channel request
//   in_data    channel i data at [i*WIDTH +: WIDTH]
//   in_ready   one-hot or zero; channel i accepted this cycle
//   out_valid  output register holds a valid item
//   out_data   data of the held item
//   out_sel    index of the channel that supplied the held item
//   out_ready  downstream accepts the held item this cycle
// -----------------------------------------------------------------------------
module rr_arb_mux #(
    parameter  int WIDTH = 16,
    parameter  int N     = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_W-1:0]     out_sel,
    input  logic                 out_ready
);

    // Index of the channel served by the most recent transfer. The
    // round-robin search begins one past this index.
    logic [SEL_W-1:0] ptr;

    logic             can_load;
    logic             gnt_any;
    logic [SEL_W-1:0] gnt_idx;
    logic [WIDTH-1:0] gnt_data;
    logic             xfer;

    int               best_dist;
    int               cur_dist;

    // The output register can take a new item when it is empty or when its
    // current item leaves this cycle.
    assign can_load = !out_valid || out_ready;

    // Grant selection. Every requesting channel gets a search distance:
    // its index in fixed-priority mode, or its position in the wrapped
    // sequence ptr+1, ptr+2, ..., ptr in round-robin mode. The requester
    // with the smallest distance wins, which gives exactly one grant.
    // NOTE: every signal driven here gets a default first, so no path
    // through the loop leaves a value unassigned and no latch is inferred.
    always_comb begin
        gnt_any   = 1'b0;
        gnt_idx   = '0;
        gnt_data  = '0;
        best_dist = N;
        cur_dist  = 0;
        for (int i = 0; i < N; i++) begin
            if (!mode) begin
                cur_dist = i;
            end else if (i > int'(ptr)) begin
                cur_dist = i - int'(ptr) - 1;
            end else begin
                cur_dist = i + N - int'(ptr) - 1;
            end
            if (in_valid[i] && (cur_dist < best_dist)) begin
                best_dist = cur_dist;
                gnt_any   = 1'b1;
                gnt_idx   = SEL_W'(i);
                gnt_data  = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // A transfer happens whenever a channel is granted and the output
    // register can take it. Reset blocks acceptance even though the
    // cleared register would otherwise report room.
    assign xfer = gnt_any && can_load && !rst;

    // in_ready is derived only from grant, can_load and reset, never from
    // channel data.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = xfer && (gnt_idx == SEL_W'(i));
        end
    end

    // Output register and round-robin pointer. After reset the pointer
    // sits at N-1 so the first round-robin search starts at channel 0.
    // On consumption without a replacement only out_valid drops; data and
    // index keep their last value.
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= SEL_W'(N - 1);
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= gnt_data;
            out_sel   <= gnt_idx;
            ptr       <= gnt_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/rr_arb_mux.md
RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 Parameter WIDTH, default 16, data width per channel.
REQ-002 Parameter N, default 4, number of input channels; legal range 2..16.
REQ-003 Parameter SEL_W, default $clog2(N), width of channel index; SHALL be derived, not overridden.
REQ-004 Clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 mode  input  1  arbitration mode: 0 = fixed priority (lowest index wins), 1 = round robin.
REQ-007 in_valid  input  N  per-channel request; bit i qualifies channel i.
REQ-008 in_data  input  N*WIDTH  channel i data at bits [i*WIDTH +: WIDTH].
REQ-009 in_ready  output  N  one-hot or zero; bit i high when channel i is accepted this cycle.
REQ-010 out_valid  output  1  output register holds a valid item.
REQ-011 out_data  output  WIDTH  registered data of held item.
REQ-012 out_sel  output  SEL_W  index of the channel that supplied the held item.
REQ-013 out_ready  input  1  downstream accepts the held item this cycle.

Function
REQ-014 One output register stage; accept condition: can_load = !out_valid | out_ready.
REQ-015 Grant computed combinationally each cycle from in_valid, mode and rr pointer; at most one grant.
REQ-016 in_ready[g] = can_load & in_valid[g] for granted g; all other bits 0; in_ready SHALL NOT depend on in_data.
REQ-017 Transfer on channel g when in_valid[g] & in_ready[g]: next edge loads out_data = channel g data, out_sel = g, out_valid = 1.
REQ-018 Latency: accepted item visible on outputs exactly 1 cycle after its transfer cycle.
REQ-019 Output consumed (out_valid & out_ready) with no transfer: out_valid clears next edge; out_data/out_sel hold last value.
REQ-020 Consume and transfer in same cycle: new item loaded, out_valid stays 1; full throughput of 1 item/cycle.
REQ-021 out_valid & !out_ready: out_data, out_sel held stable; in_ready all 0; no item lost or duplicated.
REQ-022 Mode 0: grant = lowest-index asserted in_valid bit.
REQ-023 Mode 1: search starts at (ptr+1) mod N, wraps through N-1 to 0, grants first asserted bit.
REQ-024 ptr (SEL_W bits) updates to g only on a transfer; unchanged otherwise, including in mode 0 cycles without transfer; ptr updates on mode-0 transfers too.
REQ-025 Wrap-around: ptr = N-1 searches from index 0.
REQ-026 No in_valid bits set: no grant, in_ready = 0, ptr unchanged.
REQ-027 Mode change takes effect on the cycle it is sampled; ptr retained across changes.
REQ-028 Round-robin fairness: with all N requesters continuously valid and out_ready = 1, each channel granted exactly once per N consecutive transfers.

Reset
REQ-029 Reset asserted: immediately out_valid = 0, out_data = 0, out_sel = 0, ptr = N-1, independent of Clk.
REQ-030 in_ready = 0 while Reset high.
REQ-031 Reset mid-operation discards any held item; first grant after release follows REQ-025 (search from 0).

Verification
REQ-032 Reset then in_valid = 4'b1111, mode = 1, out_ready = 1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3, out_valid continuous from cycle after first transfer.
REQ-033 mode = 0, in_valid = 4'b1010, out_ready = 1 -> every transfer from channel 1; channel 3 starved; in_ready = 4'b0010.
REQ-034 Load in_data ch2 = 16'hBEEF, hold out_ready = 0 for 5 cycles -> out_data = 16'hBEEF, out_sel = 2 stable, in_ready = 0; raise out_ready -> next item loads same cycle consumption occurs.
REQ-035 mode = 1, ptr = 3, in_valid = 4'b1001 -> grant 0; next cycle grant 3; confirms wrap-around.
REQ-036 Assert Reset asynchronously between edges while out_valid = 1 -> out_valid drops before next edge; after release with in_valid = 4'b0110, mode = 1, first out_sel = 1.
REQ-037 Parametric run N = 3, WIDTH = 8: all-valid round robin yields 0,1,2,0; SEL_W = 2; no X on outputs.
